// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the N:1 arbitrated output mux.
// Imported by the interface, the picker and the top level.
package arb_mux_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Channel-index width that stays at least one bit wide for tiny N.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Valid/ready bundle between N requesters, the arbiter and one downstream consumer.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface arb_mux_if
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = sel_width(N)
);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready
    );

endinterface

// File: rtl/arb_mux_rr_picker.sv
// Rotating-mask priority encoder: first requester at or above ptr, else lowest requester.
// With ptr tied to zero it degenerates into a plain fixed-priority encoder.
module rr_picker
    import arb_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [N-1:0] masked;

    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i >= int'(ptr));
        end
    end

    // Scanning downward lets the lowest matching index win; the masked pass overrides the wrap pass.
    always_comb begin
        gnt_idx = '0;
        gnt_any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_idx = SELW'(i);
            end
        end
        if (|masked) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (masked[i]) begin
                    gnt_idx = SELW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N:1 valid/ready arbiter with a single registered output stage.
// Fixed-priority or round-robin selection; one word per cycle with no bubbles.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int        WIDTH = 32,
    parameter int        N     = 4,
    parameter arb_mode_e MODE  = ARB_RR
) (
    input  logic     clk,
    input  logic     reset_n,
    arb_mux_if.slave bus
);

    localparam int SELW = sel_width(N);

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  pick_ptr;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_any;
    logic             load_en;
    logic             xfer;
    logic [N-1:0]     ready;
    logic [WIDTH-1:0] pick_word;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_sel_q;

    assign pick_ptr = (MODE == ARB_RR) ? rr_ptr : '0;

    rr_picker #(
        .N    (N),
        .SELW (SELW)
    ) u_picker (
        .req     (bus.in_valid),
        .ptr     (pick_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign load_en = !out_valid_q || bus.out_ready;

    // Reset gates the accept so nothing is consumed on an edge that clears the output stage.
    always_comb begin
        ready = '0;
        if (reset_n && load_en && gnt_any) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |(ready & bus.in_valid);

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                pick_word = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Load and drain may coincide; data and index hold their last value after a pure drain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pick_word;
            out_sel_q   <= gnt_idx;
            if (MODE == ARB_RR) begin
                rr_ptr <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: fixed priority N=4, round-robin N=4 and round-robin N=3 side by side.
module tb_arb_mux;
    import arb_mux_pkg::*;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    arb_mux_if #(.WIDTH(32), .N(4)) b0 ();
    arb_mux_if #(.WIDTH(32), .N(4)) b1 ();
    arb_mux_if #(.WIDTH(32), .N(3)) b2 ();

    arb_mux #(.WIDTH(32), .N(4), .MODE(ARB_FIXED)) u_fix4 (.clk(clk), .reset_n(reset_n), .bus(b0));
    arb_mux #(.WIDTH(32), .N(4), .MODE(ARB_RR))    u_rr4  (.clk(clk), .reset_n(reset_n), .bus(b1));
    arb_mux #(.WIDTH(32), .N(3), .MODE(ARB_RR))    u_rr3  (.clk(clk), .reset_n(reset_n), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i);
        return 32'(32'h11111111 * i);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance whole clocks and land 1ns after the edge so registered outputs are settled.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        b0.in_valid = '1; b0.out_ready = 1'b1;
        b1.in_valid = '1; b1.out_ready = 1'b1;
        b2.in_valid = '1; b2.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b0.in_data[i*32 +: 32] = word(i);
            b1.in_data[i*32 +: 32] = word(i);
        end
        for (int i = 0; i < 3; i++) begin
            b2.in_data[i*32 +: 32] = word(i);
        end

        // Reset held three cycles with every channel requesting.
        applyStimulus(3);
        checkOutput("rst_fix4_ready", b0.in_ready, 4'b0000);
        checkOutput("rst_fix4_valid", b0.out_valid, 1'b0);
        checkOutput("rst_fix4_data",  b0.out_data, 32'h0);
        checkOutput("rst_fix4_sel",   b0.out_sel, 2'd0);
        checkOutput("rst_rr4_ready",  b1.in_ready, 4'b0000);
        checkOutput("rst_rr4_valid",  b1.out_valid, 1'b0);
        checkOutput("rst_rr4_data",   b1.out_data, 32'h0);
        checkOutput("rst_rr4_sel",    b1.out_sel, 2'd0);
        checkOutput("rst_rr3_ready",  b2.in_ready, 3'b000);
        checkOutput("rst_rr3_valid",  b2.out_valid, 1'b0);
        checkOutput("rst_rr3_data",   b2.out_data, 32'h0);
        checkOutput("rst_rr3_sel",    b2.out_sel, 2'd0);

        b0.in_valid = '0;
        b1.in_valid = '0;
        b2.in_valid = '0;
        reset_n     = 1'b1;
        applyStimulus(1);
        checkOutput("idle_fix4_valid", b0.out_valid, 1'b0);

        // Fixed priority: ch1 beats ch3 as long as it keeps requesting.
        b0.in_valid = 4'b1010;
        #1;
        checkOutput("fix_ready_first", b0.in_ready, 4'b0010);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1);
            checkOutput("fix_valid", b0.out_valid, 1'b1);
            checkOutput("fix_sel",   b0.out_sel, 2'd1);
            checkOutput("fix_data",  b0.out_data, 32'h11111111);
            checkOutput("fix_ready", b0.in_ready, 4'b0010);
        end
        b0.in_valid = 4'b1000;
        #1;
        checkOutput("fix_ready_ch3", b0.in_ready, 4'b1000);
        applyStimulus(1);
        checkOutput("fix_sel_ch3",  b0.out_sel, 2'd3);
        checkOutput("fix_data_ch3", b0.out_data, 32'h33333333);
        b0.in_valid = 4'b0000;
        applyStimulus(1);
        checkOutput("fix_drain_valid", b0.out_valid, 1'b0);
        checkOutput("fix_drain_sel",   b0.out_sel, 2'd3);
        checkOutput("fix_drain_data",  b0.out_data, 32'h33333333);

        // Round-robin wrap with N=3: advance pointer to 2, then requests on ch0 and ch1.
        b2.in_valid = 3'b010;
        applyStimulus(1);
        checkOutput("rr3_sel_ch1", b2.out_sel, 2'd1);
        b2.in_valid = 3'b011;
        #1;
        checkOutput("rr3_ready_wrap", b2.in_ready, 3'b001);
        applyStimulus(1);
        checkOutput("rr3_sel_ch0",  b2.out_sel, 2'd0);
        checkOutput("rr3_data_ch0", b2.out_data, 32'h0);
        checkOutput("rr3_ready_ch1", b2.in_ready, 3'b010);
        applyStimulus(1);
        checkOutput("rr3_sel_ch1b",  b2.out_sel, 2'd1);
        checkOutput("rr3_data_ch1b", b2.out_data, 32'h11111111);
        checkOutput("rr3_ready_wrap2", b2.in_ready, 3'b001);
        b2.in_valid = 3'b000;
        applyStimulus(1);
        checkOutput("rr3_drain_valid", b2.out_valid, 1'b0);

        // Round-robin N=4, all channels requesting: strict rotation with no bubbles.
        b1.in_valid = 4'b1111;
        #1;
        checkOutput("rr4_ready_first", b1.in_ready, 4'b0001);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1);
            checkOutput("rr4_valid", b1.out_valid, 1'b1);
            checkOutput("rr4_sel",   b1.out_sel, 64'(c % 4));
            checkOutput("rr4_data",  b1.out_data, word(c % 4));
        end

        // Backpressure: output frozen on ch3 word, no accepts.
        b1.out_ready = 1'b0;
        #1;
        checkOutput("bp_ready_now", b1.in_ready, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1);
            checkOutput("bp_valid", b1.out_valid, 1'b1);
            checkOutput("bp_sel",   b1.out_sel, 2'd3);
            checkOutput("bp_data",  b1.out_data, 32'h33333333);
            checkOutput("bp_ready", b1.in_ready, 4'b0000);
        end
        b1.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", b1.in_ready, 4'b0001);
        applyStimulus(1);
        checkOutput("bp_reload_valid", b1.out_valid, 1'b1);
        checkOutput("bp_reload_sel",   b1.out_sel, 2'd0);
        checkOutput("bp_reload_data",  b1.out_data, 32'h0);

        // Stall on the ch0 word, then reset: the held word must vanish.
        b1.out_ready = 1'b0;
        applyStimulus(1);
        checkOutput("rs_stall_valid", b1.out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("rs_ready_in_reset", b1.in_ready, 4'b0000);
        applyStimulus(1);
        checkOutput("rs_valid", b1.out_valid, 1'b0);
        checkOutput("rs_data",  b1.out_data, 32'h0);
        checkOutput("rs_sel",   b1.out_sel, 2'd0);
        reset_n      = 1'b1;
        b1.in_valid  = 4'b0110;
        b1.out_ready = 1'b1;
        #1;
        checkOutput("rs_ptr_cleared_ready", b1.in_ready, 4'b0010);
        applyStimulus(1);
        checkOutput("rs_after_sel", b1.out_sel, 2'd1);
        b1.in_valid = 4'b0000;
        applyStimulus(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
